interval_timer_sched: RTL and testbench

Round-robin scheduler that shares a single 16-bit up-counter between several requesters, each of which needs a timed interval of a programmable length. The block arbitrates among pending requests, grants the counter to one requester, runs the count, and signals completion back to that requester. It sits between the control-path clients and the free-running-counter resource. Those clients are sequencers that need delays or timeouts.

---
 rtl/interval_timer_sched.sv | 210 +++++++++++++++++++++
 tb/tb_interval_timer_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer_sched.sv
// interval_timer_sched
// Round-robin scheduler that lends one WIDTH-bit up-counter to N_REQ
// requesters. A granted requester gets a count of its sampled length.
// Completion is reported with a one-cycle done pulse. The requester can
// abandon the interval by dropping its req while the count runs.
module interval_timer_sched #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   len,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         done,
    output logic                     busy,
    output logic [WIDTH-1:0]         q
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [PTR_W-1:0]   ptr_r;
    logic [PTR_W-1:0]   ptr_nxt_s;
    logic [WIDTH-1:0]   cnt_len_r;
    logic [WIDTH-1:0]   cnt_len_nxt_s;
    logic [WIDTH-1:0]   q_r;
    logic [WIDTH-1:0]   q_nxt_s;
    logic [N_REQ-1:0]   grant_r;
    logic [N_REQ-1:0]   grant_nxt_s;
    logic [N_REQ-1:0]   done_r;
    logic [N_REQ-1:0]   done_nxt_s;
    logic               busy_r;
    logic               busy_nxt_s;

    logic               win_found_s;
    logic [PTR_W-1:0]   win_idx_s;
    logic [WIDTH-1:0]   win_len_s;
    logic               owner_req_s;
    logic               last_count_s;

    // Index arithmetic modulo N_REQ. Both operands are below N_REQ, so a
    // single conditional subtraction is enough.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base,
                                                 input int unsigned      off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= 32'(N_REQ)) begin
            sum = sum - 32'(N_REQ);
        end else begin
            sum = sum;
        end
        return sum[PTR_W-1:0];
    endfunction

    // Decodes a requester index into its grant/done bit.
    function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [N_REQ-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    // Round-robin search: first asserted req at or after ptr, wrapping.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_found_s && req[ptr_add(ptr_r, unsigned'(k))]) begin
                win_found_s = 1'b1;
                win_idx_s   = ptr_add(ptr_r, unsigned'(k));
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Winner's length slice, the owner's live request, and the end-of-count test.
    always_comb begin
        win_len_s    = len[32'(win_idx_s)*WIDTH +: WIDTH];
        owner_req_s  = |(req & grant_r);
        last_count_s = (q_r == (cnt_len_r - ONE));
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic. Abort takes priority over the final count.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    if (win_len_s != '0) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!owner_req_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (last_count_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and the datapath.
    always_comb begin
        grant_nxt_s   = grant_r;
        done_nxt_s    = '0;
        q_nxt_s       = q_r;
        ptr_nxt_s     = ptr_r;
        cnt_len_nxt_s = cnt_len_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    grant_nxt_s   = onehot(win_idx_s);
                    cnt_len_nxt_s = win_len_s;
                    q_nxt_s       = '0;
                    ptr_nxt_s     = ptr_add(win_idx_s, 32'd1);
                    if (win_len_s == '0) begin
                        done_nxt_s = onehot(win_idx_s);
                    end else begin
                        done_nxt_s = '0;
                    end
                end else begin
                    grant_nxt_s = '0;
                end
            end
            ST_RUN: begin
                // q stops at cnt_len-1, so the maximum length never wraps.
                if (last_count_s) begin
                    q_nxt_s = q_r;
                end else begin
                    q_nxt_s = q_r + ONE;
                end
                if (!owner_req_s) begin
                    grant_nxt_s = '0;
                    done_nxt_s  = '0;
                end else if (last_count_s) begin
                    done_nxt_s = grant_r;
                end else begin
                    done_nxt_s = '0;
                end
            end
            ST_DONE: begin
                grant_nxt_s = '0;
                done_nxt_s  = '0;
            end
            default: begin
                grant_nxt_s = '0;
                done_nxt_s  = '0;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_r   <= '0;
            done_r    <= '0;
            busy_r    <= 1'b0;
            q_r       <= '0;
            ptr_r     <= '0;
            cnt_len_r <= '0;
        end else begin
            grant_r   <= grant_nxt_s;
            done_r    <= done_nxt_s;
            busy_r    <= busy_nxt_s;
            q_r       <= q_nxt_s;
            ptr_r     <= ptr_nxt_s;
            cnt_len_r <= cnt_len_nxt_s;
        end
    end

    assign grant = grant_r;
    assign done  = done_r;
    assign busy  = busy_r;
    assign q     = q_r;

endmodule

// File: tb/tb_interval_timer_sched.sv
// Self-checking bench for interval_timer_sched (N_REQ=4, WIDTH=16).
// Table-driven single transactions are expanded into per-cycle expected
// records held in a scoreboard queue. Hand-written sequences cover
// fairness, abort, async reset and the maximum length.
module tb_interval_timer_sched;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] len;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [15:0] q;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [3:0]  grant;
        logic [3:0]  done;
        logic [15:0] q;
        logic        busy;
    } exp_t;

    typedef struct {
        logic [3:0]  req;
        logic [63:0] len;
        int          win;
        int          exp_len;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];

    interval_timer_sched #(.N_REQ(4), .WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected per-cycle outputs for one granted interval of length L,
    // followed by the mandatory idle cycle.
    task automatic push_txn(input int win, input int L);
        logic [3:0]  oh;
        logic [15:0] qf;
        oh = 4'b0001 << win;
        qf = (L == 0) ? 16'd0 : 16'(L - 1);
        for (int k = 0; k < L; k++) begin
            sb.push_back('{grant: oh, done: 4'b0000, q: 16'(k), busy: 1'b1});
        end
        sb.push_back('{grant: oh, done: oh, q: qf, busy: 1'b1});
        sb.push_back('{grant: 4'b0000, done: 4'b0000, q: qf, busy: 1'b0});
    endtask

    // Step the clock once per queued record and compare.
    task automatic drain(input bit drop_at_end);
        exp_t e;
        while (sb.size() > 0) begin
            step();
            e = sb.pop_front();
            chk("grant", 32'(grant), 32'(e.grant));
            chk("done",  32'(done),  32'(e.done));
            chk("q",     32'(q),     32'(e.q));
            chk("busy",  32'(busy),  32'(e.busy));
            if (drop_at_end && sb.size() == 1) begin
                req = 4'b0000;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        req      = 4'b0000;
        len      = 64'd0;

        // ptr walks 0 -> 1 -> 3 -> 0 -> 2 -> 1 -> 2 -> 0 through the table
        vecs[0] = '{4'b0001, {16'd0, 16'd0, 16'd0, 16'd5}, 0, 5};
        vecs[1] = '{4'b0100, {16'd0, 16'd0, 16'd9, 16'd9}, 2, 0};
        vecs[2] = '{4'b1010, {16'd4, 16'd0, 16'd3, 16'd0}, 3, 4};
        vecs[3] = '{4'b1010, {16'd4, 16'd0, 16'd3, 16'd0}, 1, 3};
        vecs[4] = '{4'b0011, {16'd0, 16'd0, 16'd2, 16'd1}, 0, 1};
        vecs[5] = '{4'b1111, {16'd4, 16'd5, 16'd6, 16'd7}, 1, 6};
        vecs[6] = '{4'b1001, {16'd0, 16'd0, 16'd0, 16'd2}, 3, 0};

        // Reset state
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_q",     32'(q),     32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven single transactions
        for (int i = 0; i < 7; i++) begin
            req = vecs[i].req;
            len = vecs[i].len;
            push_txn(vecs[i].win, vecs[i].exp_len);
            drain(1'b1);
        end

        // Idle with no requests: nothing granted
        step();
        chk("idle_grant", 32'(grant), 32'd0);
        chk("idle_busy",  32'(busy),  32'd0);

        // Round-robin fairness: 0,1,2,3,0 with one idle cycle between grants
        do_reset();
        req = 4'b1111;
        len = {16'd2, 16'd2, 16'd2, 16'd2};
        push_txn(0, 2);
        push_txn(1, 2);
        push_txn(2, 2);
        push_txn(3, 2);
        push_txn(0, 2);
        drain(1'b1);

        // Abort: req1 drops at q=10, then req3 wins with ptr=2
        do_reset();
        req = 4'b0010;
        len = {16'd1000, 16'd0, 16'd100, 16'd0};
        step();
        chk("ab_grant0", 32'(grant), 32'b0010);
        chk("ab_q0",     32'(q),     32'd0);
        repeat (10) step();
        chk("ab_q10",     32'(q),     32'd10);
        chk("ab_grant10", 32'(grant), 32'b0010);
        req = 4'b1001;
        step();
        chk("ab_grant_clr", 32'(grant), 32'd0);
        chk("ab_done",      32'(done),  32'd0);
        chk("ab_busy",      32'(busy),  32'd0);
        chk("ab_q_hold",    32'(q),     32'd11);
        step();
        chk("ab_next_grant", 32'(grant), 32'b1000);
        chk("ab_next_q",     32'(q),     32'd0);
        chk("ab_next_busy",  32'(busy),  32'd1);
        repeat (5) step();
        chk("ab_run_q", 32'(q), 32'd5);

        // Async reset mid-RUN: outputs clear before the next edge
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_grant", 32'(grant), 32'd0);
        chk("ar_busy",  32'(busy),  32'd0);
        chk("ar_q",     32'(q),     32'd0);
        chk("ar_done",  32'(done),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        // req=1001 with ptr back at 0: requester 0 wins, its len is 0
        chk("ar_grant0", 32'(grant), 32'b0001);
        chk("ar_done0",  32'(done),  32'b0001);
        chk("ar_q0",     32'(q),     32'd0);
        req = 4'b0000;

        // Maximum length counts to FFFE without wrapping
        do_reset();
        req = 4'b0001;
        len = {48'd0, 16'hFFFF};
        push_txn(0, 65535);
        drain(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
